oled_text_sched: RTL and testbench
==================================

# oled_text_sched

Refresh scheduler for the 128x32 OLED text display: holds a 4-row x 16-column character buffer written by the SoC (PC/instruction readouts, banners) and sequences the OLEDCtrl character-write and update handshakes so only rows that changed are redrawn, followed by one screen update. It sits between CPU-side status logic and OLEDCtrl. It replaces ad-hoc write loops with a rate-limited, dirty-row-driven sequencer.

## Interface
- REFRESH_MIN, 100000: minimum clk cycles from one update's completion to the start of the next flush.
- HOLD_W, 17: width of the holdoff counter; must satisfy 2^HOLD_W > REFRESH_MIN.
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- host_we  in  1  write one character into the buffer this cycle.
- host_addr  in  6  [5:4] row (0 = top), [3:0] column (0 = left).
- host_data  in  8  ASCII code.
- ctrl_ready  in  1  display powered on and initialized; flushes start only when 1.
- write_start  out  1  one-cycle pulse to OLEDCtrl.
- write_base_addr  out  9  {row[1:0], col[3:0], 3'b000}.
- write_ascii_data  out  8  character for the current write.
- write_ready  in  1  OLEDCtrl write port idle.
- update_start  out  1  one-cycle pulse to OLEDCtrl.
- update_clear  out  1  constant 0.
- update_ready  in  1  OLEDCtrl update port idle.
- busy  out  1  1 in any state other than IDLE.
- dirty  out  4  per-row pending-redraw flags.
- frame_count  out  16  count of completed updates, wraps.

## Operation
- Buffer: 64 x 8 registers. Reset value 0x20 (space) for every entry. host_we writes buffer[host_addr] <= host_data and sets dirty[host_addr[5:4]]; always accepted, in every state.
- Reset: dirty = 4'b1111 (initial full draw), all other outputs 0, state IDLE, holdoff counter 0.
- States: IDLE, WR_ISSUE, WR_WAIT, UPD_ISSUE, UPD_WAIT, HOLDOFF.
- IDLE: if ctrl_ready && |dirty && write_ready -> latch row = lowest-index set dirty bit, col = 0 -> WR_ISSUE.
- WR_ISSUE: write_start = 1 for exactly one cycle; write_base_addr and write_ascii_data = buffer[{row,col}] registered this cycle and held stable until the next WR_ISSUE. If col == 0, clear dirty[row] this cycle. -> WR_WAIT.
- WR_WAIT: first cycle is a guard cycle (write_ready ignored). Afterwards, when write_ready == 1: col != 15 -> col+1, WR_ISSUE; col == 15 and any dirty bit set -> new row = lowest set dirty bit, col = 0, WR_ISSUE; otherwise -> UPD_ISSUE.
- UPD_ISSUE: update_start = 1 for one cycle -> UPD_WAIT.
- UPD_WAIT: one guard cycle, then on update_ready == 1: frame_count+1, load holdoff counter with REFRESH_MIN-1 -> HOLDOFF.
- HOLDOFF: decrement to 0, then -> IDLE. Host writes still accepted and mark rows dirty.
- Simultaneous host write and dirty clear on the same row in WR_ISSUE (col 0): set wins; row stays dirty and is redrawn later.
- Host write to the row currently being flushed after col 0: dirty bit set again; the row is redrawn in the same flush if it is the lowest dirty row at col 15.
- ctrl_ready is sampled only in IDLE. Dropping it mid-flush does not abort the flush.
- rstn asserted mid-operation: all state returns to reset values immediately and any OLEDCtrl handshake in progress is abandoned. Because dirty = 1111 after reset, the next flush redraws the full screen.

## Timing
- write_start and update_start are never high in consecutive cycles. Each is at most a one-cycle pulse per issue state.
- Per-character cost: 2 cycles plus the write_ready wait.
- IDLE to first write_start: 1 cycle (write_start is asserted in the cycle after the IDLE decision).
- The last character write completing is followed one cycle later by update_start.
- busy rises in the cycle after the IDLE decision and falls on entry to IDLE.

## Test plan
- Reset with ctrl_ready = 1 and an OLEDCtrl model whose ready drops for 5 cycles after each start -> 64 write_start pulses with addresses 0x000, 0x008 … 0x1F8 in order, all data 0x20, then 1 update_start; frame_count = 1; dirty = 0.
- After idle, host writes 'A' (0x41) at addr 6'h25 (row 2, col 5) -> exactly 16 writes covering addresses 0x100–0x178, including 0x128 = 0x41, then one update.
- Host writes to rows 3 and 1 in the same HOLDOFF window -> row 1 is flushed fully before row 3; one update only; frame_count increments by 1.
- Host write to row 0 during the col-0 WR_ISSUE of row 0 -> dirty[0] remains 1 and row 0 is flushed a second time before the update.
- ctrl_ready = 0 with dirty = 1111 -> no start pulses; busy = 0. Raise ctrl_ready -> flush begins 1 cycle later.
- Assert rstn low mid-WR_WAIT at row 2, col 7 -> outputs return to 0 and buffer to spaces asynchronously; after release, a full 64-write redraw occurs.

Source files
------------

// File: rtl/oled_text_sched.sv
// Dirty-row refresh scheduler for the 4x16 OLED text display.
// Redraws only changed rows through OLEDCtrl, then issues one rate-limited screen update.
module oled_text_sched #(
    parameter int unsigned REFRESH_MIN = 100000,
    parameter int unsigned HOLD_W      = 17
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        host_we,
    input  logic [5:0]  host_addr,
    input  logic [7:0]  host_data,
    input  logic        ctrl_ready,
    output logic        write_start,
    output logic [8:0]  write_base_addr,
    output logic [7:0]  write_ascii_data,
    input  logic        write_ready,
    output logic        update_start,
    output logic        update_clear,
    input  logic        update_ready,
    output logic        busy,
    output logic [3:0]  dirty,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_WAIT, UPD_ISSUE, UPD_WAIT, HOLDOFF
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [3:0]          col_q, col_d;
    logic                guard_q, guard_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                clr_row;
    logic                frame_inc;
    logic [3:0]          dirty_set, dirty_clr;
    logic [7:0]          buffer [64];

    function automatic logic [1:0] lowest_row(input logic [3:0] d);
        if (d[0])      return 2'd0;
        else if (d[1]) return 2'd1;
        else if (d[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign update_clear = 1'b0;
    assign dirty_set    = host_we ? (4'b0001 << host_addr[5:4]) : 4'b0000;
    assign dirty_clr    = clr_row ? (4'b0001 << row_q) : 4'b0000;

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        guard_d   = 1'b0;
        hold_d    = hold_q;
        clr_row   = 1'b0;
        frame_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_ready && (|dirty) && write_ready) begin
                    row_d   = lowest_row(dirty);
                    col_d   = 4'd0;
                    state_d = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                clr_row = (col_q == 4'd0);
                guard_d = 1'b1;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (!guard_q && write_ready) begin
                    if (col_q != 4'd15) begin
                        col_d   = col_q + 4'd1;
                        state_d = WR_ISSUE;
                    end else if (|dirty) begin
                        row_d   = lowest_row(dirty);
                        col_d   = 4'd0;
                        state_d = WR_ISSUE;
                    end else begin
                        state_d = UPD_ISSUE;
                    end
                end
            end
            UPD_ISSUE: begin
                guard_d = 1'b1;
                state_d = UPD_WAIT;
            end
            UPD_WAIT: begin
                if (!guard_q && update_ready) begin
                    frame_inc = 1'b1;
                    hold_d    = HOLD_W'(REFRESH_MIN - 1);
                    state_d   = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - HOLD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State, control and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            row_q            <= 2'd0;
            col_q            <= 4'd0;
            guard_q          <= 1'b0;
            hold_q           <= '0;
            dirty            <= 4'b1111;
            frame_count      <= 16'd0;
            write_start      <= 1'b0;
            write_base_addr  <= 9'd0;
            write_ascii_data <= 8'd0;
            update_start     <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            guard_q      <= guard_d;
            hold_q       <= hold_d;
            dirty        <= (dirty & ~dirty_clr) | dirty_set;
            write_start  <= (state_d == WR_ISSUE);
            update_start <= (state_d == UPD_ISSUE);
            busy         <= (state_d != IDLE);
            if (frame_inc) frame_count <= frame_count + 16'd1;
            // Character and address are captured on entry to WR_ISSUE and held until the next one
            if (state_d == WR_ISSUE) begin
                write_base_addr  <= {row_d, col_d, 3'b000};
                write_ascii_data <= buffer[{row_d, col_d}];
            end
        end
    end

    // Character buffer, host writes accepted in every state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) buffer[i] <= 8'h20;
        end else if (host_we) begin
            buffer[host_addr] <= host_data;
        end
    end

endmodule

// File: tb/tb_oled_text_sched.sv
// Scoreboarded bench for oled_text_sched with a latency-randomizing OLEDCtrl responder.
module tb_oled_text_sched;

    localparam int unsigned REFRESH_MIN = 40;
    localparam int unsigned HOLD_W      = 8;
    localparam logic [9:0]  UPD_TOKEN   = 10'h200;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        host_we = 1'b0;
    logic [5:0]  host_addr = 6'd0;
    logic [7:0]  host_data = 8'd0;
    logic        ctrl_ready = 1'b1;
    logic        write_start;
    logic [8:0]  write_base_addr;
    logic [7:0]  write_ascii_data;
    logic        write_ready;
    logic        update_start;
    logic        update_clear;
    logic        update_ready;
    logic        busy;
    logic [3:0]  dirty;
    logic [15:0] frame_count;

    oled_text_sched #(.REFRESH_MIN(REFRESH_MIN), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .rstn(rstn),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .ctrl_ready(ctrl_ready),
        .write_start(write_start), .write_base_addr(write_base_addr),
        .write_ascii_data(write_ascii_data), .write_ready(write_ready),
        .update_start(update_start), .update_clear(update_clear),
        .update_ready(update_ready),
        .busy(busy), .dirty(dirty), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [9:0]  exp_q [$];
    logic [7:0]  mbuf [64];
    logic [7:0]  prev_buf [64];
    logic [3:0]  mdirty = 4'hf;
    int unsigned mframe = 0;
    int unsigned fixed_lat = 5;
    int unsigned wcnt = 0;
    int unsigned ucnt = 0;
    logic        ws_prev = 1'b0;
    logic        us_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // OLEDCtrl model: ready drops for a few cycles after each start
    always @(posedge clk) begin
        if (write_start) wcnt <= (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 5);
        else if (wcnt != 0) wcnt <= wcnt - 1;
        if (update_start) ucnt <= (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 5);
        else if (ucnt != 0) ucnt <= ucnt - 1;
    end
    assign write_ready  = (wcnt == 0);
    assign update_ready = (ucnt == 0);

    // Reference buffer; prev_buf holds the contents seen by the edge that latches a write
    always @(posedge clk) begin
        prev_buf = mbuf;
        if (!rstn) begin
            for (int i = 0; i < 64; i++) mbuf[i] = 8'h20;
        end else if (host_we) begin
            mbuf[host_addr] = host_data;
        end
    end

    // Monitor: pop expected transactions as start pulses appear
    always @(negedge clk) begin
        logic [9:0] e;
        if (rstn) begin
            if (write_start) begin
                check("write_start_gap", 32'(ws_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %0h expected none", write_base_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'({1'b0, write_base_addr}), 32'(e));
                    check("write_data", 32'(write_ascii_data), 32'(prev_buf[write_base_addr[8:3]]));
                end
            end
            if (update_start) begin
                check("update_start_gap", 32'(us_prev), 32'd0);
                check("update_clear", 32'(update_clear), 32'd0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_update: got update expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("update_order", 32'(e), 32'(UPD_TOKEN));
                end
            end
        end
        ws_prev = rstn & write_start;
        us_prev = rstn & update_start;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_data = d;
        mdirty[a[5:4]] = 1'b1;
        cyc(1);
        host_we = 1'b0;
    endtask

    task automatic push_rows(input logic [3:0] mask, input bit with_update);
        for (int r = 0; r < 4; r++)
            if (mask[r])
                for (int c = 0; c < 16; c++) exp_q.push_back({1'b0, 2'(r), 4'(c), 3'b000});
        if (with_update) exp_q.push_back(UPD_TOKEN);
    endtask

    task automatic settle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin cyc(1); n++; end
        check(name, 32'(n < 5000), 32'd1);
        if (n >= 5000) exp_q.delete();
    endtask

    task automatic wait_q_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin cyc(1); n++; end
        check(name, 32'(n < 5000), 32'd1);
    endtask

    initial begin
        logic [5:0] a;
        logic [7:0] d;
        int unsigned nw;

        // Reset state with ctrl_ready high
        cyc(3);
        check("rst_write_start", 32'(write_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dirty", 32'(dirty), 32'hf);
        check("rst_frame", 32'(frame_count), 32'd0);
        check("rst_addr", 32'(write_base_addr), 32'd0);

        // Initial full-screen draw
        push_rows(4'hf, 1'b1);
        mdirty = 4'h0;
        rstn = 1'b1;
        settle("full_draw_done");
        mframe++;
        check("full_draw_frame", 32'(frame_count), 32'(mframe));
        check("full_draw_dirty", 32'(dirty), 32'd0);

        // Single character in row 2 redraws only row 2
        push_rows(4'b0100, 1'b1);
        host_write(6'h25, 8'h41);
        mdirty = 4'h0;
        wait_q_empty("row2_flush_done");
        mframe++;

        // Rows 3 and 1 written during holdoff: row 1 drawn first, one update
        cyc(3);
        host_write(6'h3a, 8'h42);
        host_write(6'h11, 8'h43);
        check("holdoff_dirty", 32'(dirty), 32'b1010);
        check("holdoff_busy", 32'(busy), 32'd1);
        push_rows(4'b1010, 1'b1);
        mdirty = 4'h0;
        settle("rows13_done");
        mframe++;
        check("rows13_frame", 32'(frame_count), 32'(mframe));

        // Write to row 0 coinciding with its col-0 dirty clear: row 0 drawn twice
        ctrl_ready = 1'b0;
        cyc(1);
        host_write(6'h03, 8'h58);
        cyc(5);
        check("not_ready_busy", 32'(busy), 32'd0);
        check("not_ready_dirty", 32'(dirty), 32'b0001);
        push_rows(4'b0001, 1'b0);
        push_rows(4'b0001, 1'b1);
        ctrl_ready = 1'b1;
        cyc(1);
        check("first_write_latency", 32'(write_start), 32'd1);
        host_write(6'h03, 8'h59);
        check("set_wins_dirty0", 32'(dirty[0]), 32'd1);
        mdirty = 4'h0;
        settle("row0_twice_done");
        mframe++;
        check("row0_twice_frame", 32'(frame_count), 32'(mframe));

        // Randomized rows and characters with random OLEDCtrl latency
        fixed_lat = 0;
        for (int it = 0; it < 6; it++) begin
            ctrl_ready = 1'b0;
            nw = $urandom_range(1, 6);
            for (int k = 0; k < int'(nw); k++) begin
                a = 6'($urandom);
                d = 8'($urandom_range(32, 126));
                host_write(a, d);
            end
            check("rand_dirty", 32'(dirty), 32'(mdirty));
            push_rows(mdirty, 1'b1);
            mdirty = 4'h0;
            ctrl_ready = 1'b1;
            settle("rand_flush_done");
            mframe++;
            check("rand_frame", 32'(frame_count), 32'(mframe));
        end

        // Reset mid-WR_WAIT at row 2, col 7
        fixed_lat = 5;
        ctrl_ready = 1'b0;
        cyc(1);
        host_write(6'h27, 8'h5a);
        for (int c = 0; c < 8; c++) exp_q.push_back({1'b0, 2'd2, 4'(c), 3'b000});
        ctrl_ready = 1'b1;
        wait_q_empty("pre_reset_writes");
        rstn = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_dirty", 32'(dirty), 32'hf);
        check("async_rst_frame", 32'(frame_count), 32'd0);
        check("async_rst_data", 32'(write_ascii_data), 32'd0);
        check("async_rst_addr", 32'(write_base_addr), 32'd0);
        ctrl_ready = 1'b0;
        mframe = 0;
        cyc(2);
        rstn = 1'b1;
        cyc(10);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_dirty", 32'(dirty), 32'hf);
        push_rows(4'hf, 1'b1);
        mdirty = 4'h0;
        ctrl_ready = 1'b1;
        cyc(1);
        check("redraw_latency", 32'(write_start), 32'd1);
        settle("redraw_done");
        mframe++;
        check("redraw_frame", 32'(frame_count), 32'(mframe));
        check("redraw_dirty", 32'(dirty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
